btb_predictor: RTL and testbench
================================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL provide parameter PC_W, default 11, PC width in bits (word-addressed PC).
REQ-002 SHALL provide parameter IDX_W, default 6, index width; table depth = 2**IDX_W entries.
REQ-003 SHALL provide parameter CNT_W, default 2, saturating-counter width; CNT_W >= 1.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 pc_fetch  in  PC_W  PC to look up.
REQ-007 fetch_valid  in  1  lookup request this cycle.
REQ-008 pred_target  out  PC_W  predicted target, registered.
REQ-009 pred_hit  out  1  valid entry with matching tag found, registered.
REQ-010 pred_taken  out  1  hit and counter MSB = 1, registered.
REQ-011 upd_valid  in  1  resolved-branch update request.
REQ-012 upd_pc  in  PC_W  PC of the resolved branch.
REQ-013 upd_target  in  PC_W  resolved target.
REQ-014 upd_taken  in  1  resolved direction.
REQ-015 ready  out  1  1 = table initialised, lookups and updates accepted.

Function
REQ-016 Entry fields SHALL be valid (1), tag (PC_W-IDX_W), target (PC_W) and counter (CNT_W).
REQ-017 Index SHALL be pc[IDX_W-1:0]; tag SHALL be pc[PC_W-1:IDX_W].
REQ-018 Lookup latency SHALL be 1 cycle: outputs update on the edge after fetch_valid=1 && ready=1.
REQ-019 pred_hit SHALL be 1 iff the indexed entry is valid and its tag equals the tag of pc_fetch.
REQ-020 On a miss, pred_target SHALL be 0 and pred_taken SHALL be 0.
REQ-021 When fetch_valid=0, all three pred_* outputs SHALL be 0 on the next edge.
REQ-022 Update on a tag hit: counter SHALL increment if upd_taken, else decrement, saturating at 2**CNT_W-1 and at 0.
REQ-023 Update on a tag hit with upd_taken=1: target SHALL be overwritten with upd_target.
REQ-024 Update on a miss with upd_taken=1: the entry SHALL be allocated or replaced with valid=1, the new tag, upd_target and counter = weakly-taken (MSB=1, rest 0).
REQ-025 Update on a miss with upd_taken=0: the table SHALL be left unchanged.
REQ-026 Same-cycle lookup and update to the same index SHALL be read-first: the lookup returns the pre-update contents.
REQ-027 Updates SHALL take effect at the edge they are sampled, with one write per cycle.
REQ-028 The FSM SHALL have two states, CLEAR and RUN.
REQ-029 CLEAR SHALL sweep indices 0 .. 2**IDX_W-1, one per cycle, writing valid=0 and counter = weakly-not-taken (MSB=0, rest 1).
REQ-030 After the last index, the FSM SHALL move to RUN and ready SHALL rise on that edge.
REQ-031 During CLEAR, fetch_valid and upd_valid SHALL be ignored and pred_* SHALL be held at 0.

Reset
REQ-032 rst=1 SHALL force state to CLEAR, sweep counter to 0, ready=0, pred_target=0, pred_hit=0 and pred_taken=0.
REQ-033 rst asserted mid-sweep or in RUN SHALL restart the sweep from index 0.
REQ-034 ready SHALL assert exactly 2**IDX_W cycles after the last cycle of rst=1.

Structure
REQ-035 Header btb_defs.vh SHALL hold the default PC_W/IDX_W/CNT_W and the CLEAR/RUN state encodings.
REQ-036 Entry storage SHALL be one sub-module, btb_entry_ram, with one registered read port, one write port and read-first behaviour.
REQ-037 Counter saturation and the allocation policy SHALL reside in btb_predictor, not in btb_entry_ram.

Verification
REQ-038 Reset for 1 cycle with defaults -> ready=0 for 64 cycles then 1; lookup of pc 0x000 -> hit=0, target=0.
REQ-039 upd pc=0x045, target=0x123, taken=1; then lookup 0x045 -> hit=1, taken=1, target=0x123 one cycle after request.
REQ-040 Two not-taken updates on 0x045 -> counter 10->01->00, taken=0, hit=1; three further not-taken updates -> counter stays 00.
REQ-041 Alias check: upd pc=0x085 (same index 5, different tag), taken=1 -> entry replaced; lookup 0x045 -> hit=0; lookup 0x085 -> hit=1.
REQ-042 Same-cycle lookup and update of 0x10A (entry empty) -> hit=0 that cycle; next lookup -> hit=1.
REQ-043 rst pulsed at sweep index 30 -> ready stays 0 for a further 64 cycles; all prior entries read as miss.

Source files
------------

// File: rtl/btb_predictor_pkg.sv
// rtl/btb_predictor_pkg.sv - shared BTB defaults and FSM state type
package btb_predictor_pkg;
`include "btb_defs.vh"

  localparam int PC_W_DEF  = `BTB_PC_W;
  localparam int IDX_W_DEF = `BTB_IDX_W;
  localparam int CNT_W_DEF = `BTB_CNT_W;

  typedef enum logic {
    CLEAR = `BTB_ST_CLEAR,
    RUN   = `BTB_ST_RUN
  } state_t;
endpackage

// File: rtl/btb_defs.vh
// rtl/btb_defs.vh - default BTB geometry and FSM state encodings
`ifndef BTB_DEFS_VH
`define BTB_DEFS_VH

`define BTB_PC_W     11
`define BTB_IDX_W    6
`define BTB_CNT_W    2

`define BTB_ST_CLEAR 1'b0
`define BTB_ST_RUN   1'b1

`endif

// File: rtl/btb_predictor_entry_ram.sv
// rtl/btb_predictor_entry_ram.sv - BTB entry storage, registered read-first lookup port
module btb_entry_ram #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] peek_addr,
  output logic [DW-1:0] peek_data
);
  logic [DW-1:0] mem [1<<AW];

  // Read and write share one edge, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  // Unregistered view for the update path's read-modify-write.
  assign peek_data = mem[peek_addr];
endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with saturating direction counters
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_fetch,
  input  logic            fetch_valid,
  output logic [PC_W-1:0] pred_target,
  output logic            pred_hit,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  output logic            ready
);
  localparam int TAG_W = PC_W - IDX_W;
  localparam int DW    = 1 + TAG_W + PC_W + CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep, sweep_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    case (state)
      CLEAR: begin
        sweep_nxt = sweep + 1'b1;
        if (sweep == '1) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready = (state == RUN);

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;
  logic [DW-1:0]    peek;

  btb_entry_ram #(.AW(IDX_W), .DW(DW)) u_ram (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (pc_fetch[IDX_W-1:0]),
    .rdata     (rdata),
    .peek_addr (upd_pc[IDX_W-1:0]),
    .peek_data (peek)
  );

  logic             u_valid;
  logic [TAG_W-1:0] u_tag;
  logic [PC_W-1:0]  u_target;
  logic [CNT_W-1:0] u_cnt, cnt_nxt;
  logic             u_hit;

  assign u_valid  = peek[DW-1];
  assign u_tag    = peek[DW-2 -: TAG_W];
  assign u_target = peek[CNT_W +: PC_W];
  assign u_cnt    = peek[CNT_W-1:0];
  assign u_hit    = u_valid && (u_tag == upd_pc[PC_W-1:IDX_W]);

  always_comb begin
    cnt_nxt = u_cnt;
    if (upd_taken) begin
      if (u_cnt != CNT_MAX) cnt_nxt = u_cnt + 1'b1;
    end else begin
      if (u_cnt != '0) cnt_nxt = u_cnt - 1'b1;
    end
  end

  // Sweep writes own the port during CLEAR; in RUN a not-taken miss leaves the table alone.
  always_comb begin
    we    = 1'b0;
    waddr = sweep;
    wdata = {1'b0, {TAG_W{1'b0}}, {PC_W{1'b0}}, CNT_WNT};
    if (!rst) begin
      if (state == CLEAR) begin
        we = 1'b1;
      end else if (upd_valid) begin
        waddr = upd_pc[IDX_W-1:0];
        if (u_hit) begin
          we    = 1'b1;
          wdata = {1'b1, u_tag, (upd_taken ? upd_target : u_target), cnt_nxt};
        end else if (upd_taken) begin
          we    = 1'b1;
          wdata = {1'b1, upd_pc[PC_W-1:IDX_W], upd_target, CNT_WT};
        end
      end
    end
  end

  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid <= 1'b0;
      lk_tag   <= '0;
    end else begin
      lk_valid <= fetch_valid && ready;
      lk_tag   <= pc_fetch[PC_W-1:IDX_W];
    end
  end

  assign pred_hit    = lk_valid && rdata[DW-1] && (rdata[DW-2 -: TAG_W] == lk_tag);
  assign pred_taken  = pred_hit && rdata[CNT_W-1];
  assign pred_target = pred_hit ? rdata[CNT_W +: PC_W] : '0;
endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor
module tb_btb_predictor;
  localparam int PC_W = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] pc_fetch;
  logic            fetch_valid;
  logic [PC_W-1:0] pred_target;
  logic            pred_hit;
  logic            pred_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic [PC_W-1:0] upd_target;
  logic            upd_taken;
  logic            ready;

  btb_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .pc_fetch    (pc_fetch),
    .fetch_valid (fetch_valid),
    .pred_target (pred_target),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Expected {hit, taken, target} per issued lookup, plus a label.
  logic [PC_W+1:0] exp_q[$];
  string           lbl_q[$];
  logic            exp_lookup = 1'b0;
  logic            pend = 1'b0;

  always @(posedge clk) pend <= exp_lookup;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        logic [PC_W+1:0] e;
        string           l;
        e = exp_q.pop_front();
        l = lbl_q.pop_front();
        check({l, "_hit"},    int'(pred_hit),    int'(e[PC_W+1]));
        check({l, "_taken"},  int'(pred_taken),  int'(e[PC_W]));
        check({l, "_target"}, int'(pred_target), int'(e[PC_W-1:0]));
      end
    end
  end

  task automatic lookup(input string l, input logic [PC_W-1:0] pc,
                        input logic h, input logic t, input logic [PC_W-1:0] tgt);
    fetch_valid = 1'b1;
    pc_fetch    = pc;
    exp_lookup  = 1'b1;
    exp_q.push_back({h, t, tgt});
    lbl_q.push_back(l);
    @(negedge clk);
    fetch_valid = 1'b0;
    exp_lookup  = 1'b0;
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string l, input int exp_cycles);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(l, n, exp_cycles);
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; pc_fetch = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    @(negedge clk);
    check("rst_ready",  int'(ready),       0);
    check("rst_hit",    int'(pred_hit),    0);
    check("rst_taken",  int'(pred_taken),  0);
    check("rst_target", int'(pred_target), 0);
    rst = 1'b0;
    wait_ready("ready_latency", 64);

    lookup("empty_000", 11'h000, 1'b0, 1'b0, 11'h000);

    update(11'h045, 11'h123, 1'b1);
    lookup("alloc_045", 11'h045, 1'b1, 1'b1, 11'h123);

    update(11'h045, 11'h3FF, 1'b0);
    lookup("nt1_045", 11'h045, 1'b1, 1'b0, 11'h123);
    update(11'h045, 11'h3FF, 1'b0);
    lookup("nt2_045", 11'h045, 1'b1, 1'b0, 11'h123);
    for (int i = 0; i < 3; i++) update(11'h045, 11'h3FF, 1'b0);
    lookup("nt_sat_045", 11'h045, 1'b1, 1'b0, 11'h123);
    update(11'h045, 11'h123, 1'b1);
    lookup("lo_sat_045", 11'h045, 1'b1, 1'b0, 11'h123);
    update(11'h045, 11'h1AB, 1'b1);
    lookup("retarget_045", 11'h045, 1'b1, 1'b1, 11'h1AB);
    for (int i = 0; i < 3; i++) update(11'h045, 11'h1AB, 1'b1);
    update(11'h045, 11'h3FF, 1'b0);
    lookup("hi_sat_045", 11'h045, 1'b1, 1'b1, 11'h1AB);

    update(11'h085, 11'h055, 1'b1);
    lookup("alias_old_045", 11'h045, 1'b0, 1'b0, 11'h000);
    lookup("alias_new_085", 11'h085, 1'b1, 1'b1, 11'h055);
    update(11'h0C5, 11'h077, 1'b0);
    lookup("nt_miss_keep_085", 11'h085, 1'b1, 1'b1, 11'h055);
    lookup("nt_miss_0c5", 11'h0C5, 1'b0, 1'b0, 11'h000);

    // Lookup and allocating update of the same PC in one cycle.
    upd_valid = 1'b1; upd_pc = 11'h10A; upd_target = 11'h0F0; upd_taken = 1'b1;
    lookup("same_cycle_10a", 11'h10A, 1'b0, 1'b0, 11'h000);
    upd_valid = 1'b0;
    lookup("after_10a", 11'h10A, 1'b1, 1'b1, 11'h0F0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lookup("clear_085", 11'h085, 1'b0, 1'b0, 11'h000);
    repeat (29) @(negedge clk);
    check("mid_sweep_ready", int'(ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("restart_latency", 64);

    lookup("cleared_085", 11'h085, 1'b0, 1'b0, 11'h000);
    lookup("cleared_10a", 11'h10A, 1'b0, 1'b0, 11'h000);
    lookup("cleared_045", 11'h045, 1'b0, 1'b0, 11'h000);

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
